// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-side memory responder with LL/SC reservation
module dmem_responder #(
  parameter int ADDR_W   = 32,
  parameter int LINK_LSB = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic              datomic,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [31:0]       dstore,
  output logic              dhit,
  output logic [31:0]       dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [31:0]       ramstore,
  input  logic [31:0]       ramload,
  input  logic              ramdone,
  input  logic              snoop_wr,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              link_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                   state_q;
  logic                     op_write_q;
  logic                     op_atomic_q;
  logic                     dhit_q;
  logic [31:0]              dload_q;
  logic                     ramREN_q;
  logic                     ramWEN_q;
  logic [ADDR_W-1:0]        ramaddr_q;
  logic [31:0]              ramstore_q;
  logic                     link_valid_q;
  logic                     link_valid_d;
  logic [ADDR_W-1:LINK_LSB] link_addr_q;
  logic [ADDR_W-1:LINK_LSB] link_addr_d;

  logic                     snoop_hits_old;
  logic                     sc_ok;
  logic                     unused_snoop_lo;

  // Byte offset within a reservation granule never matters for snoops.
  assign unused_snoop_lo = ^snoop_addr[LINK_LSB-1:0];

  // Reservation next-state: operation effects first, snoop clear applied last so it wins.
  always_comb begin
    snoop_hits_old = snoop_wr && (snoop_addr[ADDR_W-1:LINK_LSB] == link_addr_q);
    sc_ok          = link_valid_q && (daddr[ADDR_W-1:LINK_LSB] == link_addr_q) && !snoop_hits_old;
    link_valid_d   = link_valid_q;
    link_addr_d    = link_addr_q;
    case (state_q)
      IDLE: begin
        if (dWEN && datomic && !sc_ok) begin
          link_valid_d = 1'b0;
        end
      end
      ACCESS: begin
        if (ramdone) begin
          if (!op_write_q && op_atomic_q) begin
            link_valid_d = 1'b1;
            link_addr_d  = ramaddr_q[ADDR_W-1:LINK_LSB];
          end else if (op_write_q && op_atomic_q) begin
            link_valid_d = 1'b0;
          end else if (op_write_q && (ramaddr_q[ADDR_W-1:LINK_LSB] == link_addr_q)) begin
            link_valid_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
    // Compare against the post-update address so a snoop racing an LL still kills it.
    if (snoop_wr && (snoop_addr[ADDR_W-1:LINK_LSB] == link_addr_d)) begin
      link_valid_d = 1'b0;
    end
  end

  // Request FSM with registered RAM strobes and datapath response.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      op_write_q   <= 1'b0;
      op_atomic_q  <= 1'b0;
      dhit_q       <= 1'b0;
      dload_q      <= 32'd0;
      ramREN_q     <= 1'b0;
      ramWEN_q     <= 1'b0;
      ramaddr_q    <= '0;
      ramstore_q   <= 32'd0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
      case (state_q)
        IDLE: begin
          if (dREN || dWEN) begin
            op_write_q  <= dWEN;
            op_atomic_q <= datomic;
            ramaddr_q   <= daddr;
            ramstore_q  <= dstore;
            if (dWEN && datomic && !sc_ok) begin
              // Failed SC never touches RAM.
              state_q <= RESP;
              dhit_q  <= 1'b1;
              dload_q <= 32'd0;
            end else begin
              state_q  <= ACCESS;
              ramREN_q <= !dWEN;
              ramWEN_q <= dWEN;
            end
          end
        end
        ACCESS: begin
          if (ramdone) begin
            state_q  <= RESP;
            ramREN_q <= 1'b0;
            ramWEN_q <= 1'b0;
            dhit_q   <= 1'b1;
            if (!op_write_q) begin
              dload_q <= ramload;
            end else if (op_atomic_q) begin
              dload_q <= 32'd1;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
          dhit_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dhit       = dhit_q;
  assign dload      = dload_q;
  assign ramREN     = ramREN_q;
  assign ramWEN     = ramWEN_q;
  assign ramaddr    = ramaddr_q;
  assign ramstore   = ramstore_q;
  assign link_valid = link_valid_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
module tb_dmem_responder;

  logic        CLK;
  logic        nRST;
  logic        dREN;
  logic        dWEN;
  logic        datomic;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dhit;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramdone;
  logic        snoop_wr;
  logic [31:0] snoop_addr;
  logic        link_valid;

  typedef struct {
    logic [31:0] val;
    bit          care;
  } exp_t;

  exp_t sb_q[$];
  int   errors;
  int   checks;

  dmem_responder #(.ADDR_W(32), .LINK_LSB(2)) dut (
    .CLK(CLK), .nRST(nRST), .dREN(dREN), .dWEN(dWEN), .datomic(datomic),
    .daddr(daddr), .dstore(dstore), .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramdone(ramdone), .snoop_wr(snoop_wr),
    .snoop_addr(snoop_addr), .link_valid(link_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every dhit consumes one scoreboard entry.
  always @(negedge CLK) begin
    if (nRST && dhit) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dhit: got dhit=1 expected no response, dload=0x%08h", dload);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.care) chk("dload", dload, e.val);
      end
    end
  end

  task automatic do_req(input string nm, input logic ren, input logic wen, input logic at,
                        input logic [31:0] addr, input logic [31:0] data, input logic [31:0] rl,
                        input int dly, input logic acc, input logic [31:0] expv,
                        input bit care, input bit snp);
    exp_t e;
    dREN = ren; dWEN = wen; datomic = at; daddr = addr; dstore = data;
    e.val = expv; e.care = care;
    sb_q.push_back(e);
    @(posedge CLK); #1;
    if (acc) begin
      chk({nm, "_ramREN_c1"}, {31'd0, ramREN}, {31'd0, ren && !wen});
      chk({nm, "_ramWEN_c1"}, {31'd0, ramWEN}, {31'd0, wen});
      chk({nm, "_ramaddr"}, ramaddr, addr);
      if (wen) chk({nm, "_ramstore"}, ramstore, data);
      chk({nm, "_dhit_c1"}, {31'd0, dhit}, 32'd0);
      repeat (dly) begin
        @(posedge CLK); #1;
        chk({nm, "_strobe_held"}, {31'd0, ramREN | ramWEN}, 32'd1);
      end
      ramdone = 1'b1; ramload = rl;
      if (snp) begin snoop_wr = 1'b1; snoop_addr = addr; end
      @(posedge CLK); #1;
      ramdone = 1'b0; ramload = 32'd0; snoop_wr = 1'b0;
      chk({nm, "_dhit_resp"}, {31'd0, dhit}, 32'd1);
      chk({nm, "_strobes_off"}, {30'd0, ramREN, ramWEN}, 32'd0);
    end else begin
      chk({nm, "_nowrite"}, {30'd0, ramREN, ramWEN}, 32'd0);
      chk({nm, "_dhit_c1"}, {31'd0, dhit}, 32'd1);
    end
    dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0;
    @(posedge CLK); #1;
    chk({nm, "_dhit_pulse"}, {31'd0, dhit}, 32'd0);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    errors = 0; checks = 0;
    dREN = 0; dWEN = 0; datomic = 0; daddr = 0; dstore = 0;
    ramload = 0; ramdone = 0; snoop_wr = 0; snoop_addr = 0; nRST = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_outputs", {28'd0, dhit, ramREN, ramWEN, link_valid}, 32'd0);
    chk("reset_dload", dload, 32'd0);
    chk("reset_ramaddr", ramaddr, 32'd0);
    chk("reset_ramstore", ramstore, 32'd0);
    nRST = 1'b1;

    // LW: ramdone in first ACCESS cycle
    do_req("lw100", 1, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 1, 0);
    chk("lw100_link", {31'd0, link_valid}, 32'd0);

    // LL then successful SC
    do_req("ll200", 1, 0, 1, 32'h200, 32'h0, 32'h12345678, 1, 1, 32'h12345678, 1, 0);
    chk("ll200_link", {31'd0, link_valid}, 32'd1);
    do_req("sc200", 0, 1, 1, 32'h200, 32'd5, 32'h0, 0, 1, 32'd1, 1, 0);
    chk("sc200_link", {31'd0, link_valid}, 32'd0);

    // SC after reset with no LL
    do_reset();
    do_req("sc_nolink", 0, 1, 1, 32'h200, 32'd7, 32'h0, 0, 0, 32'd0, 1, 0);

    // SW to the linked word kills the SC
    do_req("ll300a", 1, 0, 1, 32'h300, 32'h0, 32'hA5A5A5A5, 0, 1, 32'hA5A5A5A5, 1, 0);
    do_req("sw300", 0, 1, 0, 32'h300, 32'h9, 32'h0, 0, 1, 32'h0, 0, 0);
    chk("sw300_link", {31'd0, link_valid}, 32'd0);
    do_req("sc300_fail", 0, 1, 1, 32'h300, 32'hB, 32'h0, 0, 0, 32'd0, 1, 0);

    // SW to a different word and a non-matching snoop leave the link
    do_req("ll300b", 1, 0, 1, 32'h300, 32'h0, 32'h5A5A5A5A, 0, 1, 32'h5A5A5A5A, 1, 0);
    do_req("sw304", 0, 1, 0, 32'h304, 32'h9, 32'h0, 2, 1, 32'h0, 0, 0);
    snoop_wr = 1'b1; snoop_addr = 32'h308;
    @(posedge CLK); #1;
    snoop_wr = 1'b0;
    chk("sw304_link", {31'd0, link_valid}, 32'd1);
    do_req("sc300_ok", 0, 1, 1, 32'h300, 32'hC, 32'h0, 0, 1, 32'd1, 1, 0);

    // Snoop on the LL completion edge wins
    do_req("ll400", 1, 0, 1, 32'h400, 32'h0, 32'h00000400, 0, 1, 32'h00000400, 1, 1);
    chk("ll400_snoop_link", {31'd0, link_valid}, 32'd0);
    do_req("sc400_fail", 0, 1, 1, 32'h400, 32'hD, 32'h0, 0, 0, 32'd0, 1, 0);

    // Reset in the middle of a stalled LW, with a live link
    do_req("ll700", 1, 0, 1, 32'h700, 32'h0, 32'h77, 0, 1, 32'h77, 1, 0);
    dREN = 1; daddr = 32'h500;
    @(posedge CLK); #1;
    chk("lw500_ramREN_c1", {31'd0, ramREN}, 32'd1);
    @(posedge CLK); #1;
    nRST = 1'b0; dREN = 0;
    @(posedge CLK); #1;
    chk("midrst_outputs", {28'd0, dhit, ramREN, ramWEN, link_valid}, 32'd0);
    chk("midrst_dload", dload, 32'd0);
    chk("midrst_ramaddr", ramaddr, 32'd0);
    nRST = 1'b1;
    ramdone = 1'b1; ramload = 32'hBAD;
    @(posedge CLK); #1;
    ramdone = 1'b0;
    chk("idle_after_rst", {29'd0, dhit, ramREN, ramWEN}, 32'd0);
    do_req("lw600", 1, 0, 0, 32'h600, 32'h0, 32'hCAFEF00D, 1, 1, 32'hCAFEF00D, 1, 0);

    repeat (3) @(posedge CLK);
    #1;
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-side memory responder for the single-cycle/pipelined MIPS datapath. It services the `dREN`/`dWEN`/`datomic` requests the datapath raises for LW, SW, LL and SC, and drives a simple handshaked RAM port. It owns the LL/SC reservation (link register) and resolves SC success or failure. It returns `dhit` with load data, or SC status, to the datapath.

## Interface
- `ADDR_W`, default 32: byte-address width of `daddr`/`ramaddr`.
- `LINK_LSB`, default 2: lowest address bit compared for reservation match (word granularity).
- `CLK` in 1: clock, all state updates on rising edge.
- `nRST` in 1: reset, synchronous, active-low.
- `dREN` in 1: datapath read request (LW, LL).
- `dWEN` in 1: datapath write request (SW, SC).
- `datomic` in 1: request is LL (with `dREN`) or SC (with `dWEN`).
- `daddr` in ADDR_W: request byte address.
- `dstore` in 32: write data.
- `dhit` out 1: one-cycle completion pulse.
- `dload` out 32: load data; for SC, 1 = success, 0 = fail; valid only while `dhit`=1.
- `ramREN` out 1: RAM read strobe.
- `ramWEN` out 1: RAM write strobe.
- `ramaddr` out ADDR_W: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data, valid with `ramdone`.
- `ramdone` in 1: RAM completion pulse.
- `snoop_wr` in 1: another agent wrote memory this cycle.
- `snoop_addr` in ADDR_W: address of that write.
- `link_valid` out 1: reservation held (debug/verification visibility).

## Operation
- Reservation state: `link_valid`, `link_addr[ADDR_W-1:LINK_LSB]`.
- Match: `addr[ADDR_W-1:LINK_LSB] == link_addr`.
- States:
  - IDLE: no RAM strobe.
  - ACCESS: RAM strobes driven from latched request.
  - RESP: `dhit`=1.
- IDLE with a request present at the edge:
  - Latch `daddr`, `dstore`, op type.
  - If `dWEN` and `dREN` are both high, treat as a write.
  - SC with `link_valid` and match: go to ACCESS as a write; mark result 1.
  - SC without a valid matching link: go straight to RESP, `dload`=0, no RAM access, link cleared.
  - LW/LL/SW: go to ACCESS.
- ACCESS:
  - Hold `ramREN` (reads) or `ramWEN` (writes) high, with `ramaddr`/`ramstore` from the latch, until `ramdone`.
  - On a `ramdone` edge, go to RESP.
  - Reads capture `ramload` into `dload`; SC loads `dload`=1.
- RESP: assert `dhit` for exactly one cycle, then return to IDLE.
- Link updates, applied on the `ramdone` edge:
  - LL sets `link_valid`=1 and `link_addr` to the LL address.
  - Successful SC clears the link.
  - SW to a matching address clears the link.
  - SW to a non-matching address leaves the link.
- Snoop: `snoop_wr` with a match clears `link_valid` on any edge, in any state.
- Simultaneous events (snoop clear has priority over every link set):
  - Snoop match on the same edge an LL sets the link: link ends cleared.
  - Snoop match on the same edge IDLE evaluates an SC: SC fails.
  - Once an SC is in ACCESS, its write completes regardless of later snoops.
- Requests arriving while not IDLE are ignored. The datapath holds the request stable until `dhit`, then may change it on that edge.

## Timing
- Reset (`nRST`=0 at an edge), including mid-ACCESS:
  - Next state IDLE.
  - `dhit`=0, `ramREN`=`ramWEN`=0, `dload`=0, `ramaddr`=0, `ramstore`=0.
  - `link_valid`=0, `link_addr`=0.
  - An outstanding RAM access is abandoned.
- All outputs are functions of registered state only; no combinational path from request inputs to `dhit` or RAM strobes.
- Request seen in IDLE at edge 0:
  - Strobes high from cycle 1.
  - `ramdone` in cycle n gives `dhit` in cycle n+1.
  - Minimum load/store latency is 2 cycles (`ramdone` in cycle 1, `dhit` in cycle 2).
- Failing SC: `dhit` in cycle 1.
- A new request is accepted at the edge after RESP, when IDLE is re-entered; back-to-back throughput is one access per 3 cycles minimum.
- `ramdone` outside ACCESS is ignored.

## Test plan
- LW 0x100, `ramload`=0xDEADBEEF, `ramdone` in first ACCESS cycle -> `ramREN` cycle 1 only, `dhit` cycle 2, `dload`=0xDEADBEEF, link unchanged.
- LL 0x200, then SC 0x200 `dstore`=5 -> `ramWEN` with `ramstore`=5, `dhit` with `dload`=1, `link_valid`=0 afterwards.
- SC 0x200 after reset with no LL -> no `ramWEN` ever, `dhit` cycle 1, `dload`=0.
- LL 0x300, then SW 0x300, then SC 0x300 -> SC fails (`dload`=0, no write). Repeat with SW 0x304 instead -> SC succeeds.
- LL 0x400; `snoop_wr`=1, `snoop_addr`=0x400 on the LL `ramdone` edge -> `link_valid`=0; following SC fails.
- LW with `ramdone` withheld 5 cycles; `nRST`=0 in cycle 3 -> cycle 4 has all outputs 0, state IDLE, no `dhit`. A new LW after reset completes normally.
